// File: rtl/ram_port_arbiter_if.sv
// One FemtoRV32-style memory bus: a master issues one-cycle read/write
// strobes and watches rbusy/wbusy until the transfer has been carried out.
interface ram_port_arbiter_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] rdata;
    logic        rbusy;
    logic        wbusy;

    modport master (
        output addr, wdata, wmask, rstrb,
        input  rdata, rbusy, wbusy
    );

    modport slave (
        input  addr, wdata, wmask, rstrb,
        output rdata, rbusy, wbusy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port block RAM with one cycle of
// read latency. Each master gets one request slot; strobes are latched into
// it, and the slots are served one at a time through the RAM port.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH    = 14,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_port_arbiter_if.slave     m0,
    ram_port_arbiter_if.slave     m1,
    output logic [ADDR_WIDTH-1:0] ram_word_address,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wmask,
    input  logic [31:0]           ram_rdata,
    output logic [1:0]            grant
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] RDATA = 1'b1;

    logic [0:0]            state;
    logic                  owner;       // master holding the port during RDATA
    logic                  last_grant;  // most recently granted master
    logic [1:0]            pend;
    logic [1:0]            is_write;
    logic [ADDR_WIDTH-1:0] addr_q  [2];
    logic [31:0]           wdata_q [2];
    logic [3:0]            wmask_q [2];
    logic [31:0]           rdata_q [2];

    logic [ADDR_WIDTH-1:0] in_word  [2];
    logic [31:0]           in_wdata [2];
    logic [3:0]            in_wmask [2];
    logic [1:0]            in_rstrb;

    logic                  win_valid;
    logic                  winner;
    logic [1:0]            done;
    logic                  addr_unused;

    // Flatten both master buses so the request slots share one code path.
    always_comb begin
        in_word[0]  = m0.addr[ADDR_WIDTH+1:2];
        in_word[1]  = m1.addr[ADDR_WIDTH+1:2];
        in_wdata[0] = m0.wdata;
        in_wdata[1] = m1.wdata;
        in_wmask[0] = m0.wmask;
        in_wmask[1] = m1.wmask;
        in_rstrb    = {m1.rstrb, m0.rstrb};
    end

    // Byte-offset bits and bits above the RAM size do not take part: the RAM aliases.
    assign addr_unused = ^{m0.addr[31:ADDR_WIDTH+2], m0.addr[1:0],
                           m1.addr[31:ADDR_WIDTH+2], m1.addr[1:0]};

    // Pick the master to serve; only meaningful while the port is idle.
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_valid = 1'b0;
        winner    = 1'b0;
        if (state == IDLE) begin
            case (pend)
                2'b01:   begin win_valid = 1'b1; winner = 1'b0; end
                2'b10:   begin win_valid = 1'b1; winner = 1'b1; end
                2'b11:   begin
                    win_valid = 1'b1;
                    winner    = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
                end
                default: begin win_valid = 1'b0; winner = 1'b0; end
            endcase
        end
    end

    // A slot retires when its write is issued or its read data is captured.
    always_comb begin
        done = 2'b00;
        if (state == RDATA) begin
            done[owner] = 1'b1;
        end else if (win_valid && is_write[winner]) begin
            done[winner] = 1'b1;
        end
    end

    // Drive the RAM port; ram_wmask is nonzero only in a write-grant cycle.
    always_comb begin
        grant            = 2'b00;
        ram_word_address = '0;
        ram_wdata        = '0;
        ram_wmask        = '0;
        if (state == RDATA) begin
            grant            = owner ? 2'b10 : 2'b01;
            ram_word_address = addr_q[owner];
        end else if (win_valid) begin
            grant            = winner ? 2'b10 : 2'b01;
            ram_word_address = addr_q[winner];
            if (is_write[winner]) begin
                ram_wdata = wdata_q[winner];
                ram_wmask = wmask_q[winner];
            end
        end
    end

    // Port FSM: writes finish in IDLE, reads spend one extra cycle in RDATA.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        last_grant <= winner;
                        owner      <= winner;
                        if (!is_write[winner]) begin
                            state <= RDATA;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request slots: capture a strobe only while the slot is empty; a write wins over a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= 2'b00;
            is_write <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                wmask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (done[i]) begin
                        pend[i] <= 1'b0;
                    end
                end else if (in_wmask[i] != 4'h0 || in_rstrb[i]) begin
                    pend[i]     <= 1'b1;
                    is_write[i] <= (in_wmask[i] != 4'h0);
                    addr_q[i]   <= in_word[i];
                    wdata_q[i]  <= in_wdata[i];
                    wmask_q[i]  <= in_wmask[i];
                end
            end
        end
    end

    // Read data is held per master until its next completed read; reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else if (state == RDATA) begin
            rdata_q[owner] <= ram_rdata;
        end
    end

    assign m0.rdata = rdata_q[0];
    assign m1.rdata = rdata_q[1];
    assign m0.rbusy = pend[0] & ~is_write[0];
    assign m1.rbusy = pend[1] & ~is_write[1];
    assign m0.wbusy = pend[0] &  is_write[0];
    assign m1.wbusy = pend[1] &  is_write[1];
endmodule
